// File: rtl/filter_pkg.sv
// filter_pkg: constants and helpers shared by the filter output path.
//   FILT_IN_W / FILT_OUT_W : sample widths at the filter's input and output.
//   SAT_MAX / SAT_MIN      : clip limits for the default 8-bit sink output.
//   sat_max_f / sat_min_f  : clip limits for an arbitrary signed width.
//   round_const            : half-LSB constant added before a right shift.
package filter_pkg;

  localparam int FILT_IN_W  = 32'sd8;
  localparam int FILT_OUT_W = 32'sd17;
  localparam int SINK_OUT_W = 32'sd8;

  function automatic int sat_max_f(input int w);
    return (32'sd1 <<< (w - 32'sd1)) - 32'sd1;
  endfunction

  function automatic int sat_min_f(input int w);
    return -(32'sd1 <<< (w - 32'sd1));
  endfunction

  function automatic int round_const(input int shift);
    return 32'sd1 <<< (shift - 32'sd1);
  endfunction

  localparam int SAT_MAX = sat_max_f(SINK_OUT_W);
  localparam int SAT_MIN = sat_min_f(SINK_OUT_W);

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with a registered head output.
//   clk   : clock, rising edge
//   rst   : synchronous active-low reset (empties the FIFO, dout=0)
//   push  : write request; ignored when full unless a pop happens in the same cycle
//   din   : write data
//   pop   : read request; ignored when empty
//   dout  : registered head entry; holds the last popped value while empty
//   full  : DEPTH entries stored
//   empty : no entries stored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             pop_ok_s, push_ok_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign dout      = dout_q;

  // Next pointers and the head value that will be visible after this edge.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    dout_d = dout_q;
    if (push_ok_s) begin
      wr_d = wr_q + (AW+1)'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_ok_s) begin
      rd_d = rd_q + (AW+1)'(1);
    end else begin
      rd_d = rd_q;
    end
    if (wr_d == rd_d) begin
      // Going empty: keep showing the value that was just popped.
      dout_d = dout_q;
    end else if (push_ok_s && (wr_q == rd_d)) begin
      // The entry being written becomes the new head.
      dout_d = din;
    end else begin
      dout_d = mem_q[rd_d[AW-1:0]];
    end
  end

  // Pointer and head-register update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      dout_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      dout_q <= dout_d;
    end
  end

  // Storage array; contents are don't-care after reset because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/filter_sink.sv
// filter_sink: decimates the filter's strobed output, rounds and saturates
// each kept sample and buffers it for a valid/ready consumer.
//   clk     : clock, rising edge
//   rst     : synchronous active-low reset
//   in      : signed input sample, valid when in_en=1
//   in_en   : input strobe (no backpressure)
//   out_rdy : downstream ready
//   out     : FIFO head sample (signed)
//   out_en  : out valid (FIFO non-empty)
//   ovf     : sticky, a kept sample was dropped on a full FIFO
//   sat     : sticky, a kept sample was clipped
module filter_sink
  import filter_pkg::*;
#(
  parameter int IN_W       = FILT_OUT_W,
  parameter int OUT_W      = SINK_OUT_W,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  input  logic             in_en,
  input  logic             out_rdy,
  output logic [OUT_W-1:0] out,
  output logic             out_en,
  output logic             ovf,
  output logic             sat
);

  localparam int                CNT_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic signed [IN_W:0] RND   = (IN_W+1)'(round_const(SHIFT));
  localparam logic signed [IN_W:0] R_MAX = (IN_W+1)'(sat_max_f(OUT_W));
  localparam logic signed [IN_W:0] R_MIN = (IN_W+1)'(sat_min_f(OUT_W));

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                keep_s;
  logic [IN_W-1:0]     in_q;
  logic                kept_q;
  logic signed [IN_W:0] sum_s, r_s;
  logic [OUT_W-1:0]    samp_s;
  logic                clip_s;
  logic [OUT_W-1:0]    stage_q;
  logic                stage_valid_q;
  logic                sat_q, ovf_q;
  logic                fifo_full_s, fifo_empty_s, pop_s;
  logic [OUT_W-1:0]    fifo_dout_s;

  // Decimation: keep the strobe that finds the counter at zero.
  always_comb begin
    cnt_d  = cnt_q;
    keep_s = in_en && (cnt_q == '0);
    if (in_en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Round half up, then clip to the signed output range.
  always_comb begin
    sum_s  = $signed({in_q[IN_W-1], in_q}) + RND;
    r_s    = sum_s >>> SHIFT;
    samp_s = r_s[OUT_W-1:0];
    clip_s = 1'b0;
    if (r_s > R_MAX) begin
      samp_s = R_MAX[OUT_W-1:0];
      clip_s = 1'b1;
    end else if (r_s < R_MIN) begin
      samp_s = R_MIN[OUT_W-1:0];
      clip_s = 1'b1;
    end else begin
      samp_s = r_s[OUT_W-1:0];
      clip_s = 1'b0;
    end
  end

  assign pop_s = !fifo_empty_s && out_rdy;

  // Input capture, requantisation stage and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q         <= '0;
      in_q          <= '0;
      kept_q        <= 1'b0;
      stage_q       <= '0;
      stage_valid_q <= 1'b0;
      sat_q         <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      in_q          <= in;
      kept_q        <= keep_s;
      stage_q       <= kept_q ? samp_s : stage_q;
      stage_valid_q <= kept_q;
      sat_q         <= sat_q | (kept_q & clip_s);
      // A full FIFO only refuses the push when nothing leaves in the same cycle.
      ovf_q         <= ovf_q | (stage_valid_q & fifo_full_s & ~pop_s);
    end
  end

  sync_fifo #(
    .WIDTH(OUT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (stage_valid_q),
    .din  (stage_q),
    .pop  (pop_s),
    .dout (fifo_dout_s),
    .full (fifo_full_s),
    .empty(fifo_empty_s)
  );

  assign out    = fifo_dout_s;
  assign out_en = !fifo_empty_s;
  assign ovf    = ovf_q;
  assign sat    = sat_q;

endmodule
